// File: rtl/stage_sequencer_if.sv
// Handshake/status bundle between the sequencer and its controller.
interface stage_sequencer_if #(
   parameter int NUM_STAGES = 5,
   parameter int DISP_W     = 3,
   parameter int TO_W       = 16
);
   logic                  run;
   logic                  abort;
   logic [NUM_STAGES-1:0] stage_en;
   logic [NUM_STAGES-1:0] stage_done;
   logic [DISP_W-1:0]     current_display;
   logic [TO_W-1:0]       timeout_limit;
   logic                  state_idle;
   logic [NUM_STAGES-1:0] stage_active;
   logic [NUM_STAGES-1:0] stage_start;
   logic                  state_display;
   logic                  done;
   logic                  error;
   logic [3:0]            error_stage;

   modport master (
      output run, abort, stage_en, stage_done, current_display, timeout_limit,
      input  state_idle, stage_active, stage_start, state_display, done, error, error_stage
   );

   modport slave (
      input  run, abort, stage_en, stage_done, current_display, timeout_limit,
      output state_idle, stage_active, stage_start, state_display, done, error, error_stage
   );
endinterface

// File: rtl/stage_sequencer.sv
// Walks the enabled pipeline stages in order, then a display phase, with a
// per-stage watchdog; all outputs come straight from registers.
module stage_sequencer #(
   parameter int NUM_STAGES = 5,
   parameter int DISP_W     = 3,
   parameter int DISP_LAST  = 4,
   parameter int TO_W       = 16
) (
   input logic               clk,
   input logic               reset,
   stage_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_STAGE, S_DISPLAY, S_ERROR} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cur_q, cur_d;
   logic [3:0]            err_stage_q, err_stage_d;
   logic [NUM_STAGES-1:0] en_q, en_d;
   logic [TO_W-1:0]       cnt_q, cnt_d;
   logic [NUM_STAGES-1:0] active_q, active_d;
   logic [NUM_STAGES-1:0] start_q, start_d;
   logic                  idle_q, idle_d;
   logic                  disp_q, disp_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic       done_sel;
   logic       first_found, next_found;
   logic [3:0] first_idx, next_idx;
   logic       timeout;
   logic       entry;

   // Lowest enabled stage for a new run, next enabled stage above the current one.
   always_comb begin
      done_sel    = 1'b0;
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
         if (cur_q == 4'(i)) done_sel = bus.stage_done[i];
         if (!first_found && bus.stage_en[i]) begin
            first_found = 1'b1;
            first_idx   = 4'(i);
         end
         if (!next_found && en_q[i] && (4'(i) > cur_q)) begin
            next_found = 1'b1;
            next_idx   = 4'(i);
         end
      end
   end

   assign timeout = (bus.timeout_limit != '0) && (cnt_q == bus.timeout_limit - TO_W'(1));

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      en_d        = en_q;
      err_stage_d = err_stage_q;
      entry       = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.run && !bus.abort) begin
               en_d = bus.stage_en;
               if (first_found) begin
                  state_d = S_STAGE;
                  cur_d   = first_idx;
                  entry   = 1'b1;
               end else begin
                  state_d = S_DISPLAY;
               end
            end
         end
         S_STAGE: begin
            // abort beats stage completion, which beats the watchdog
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (done_sel) begin
               if (next_found) begin
                  cur_d = next_idx;
                  entry = 1'b1;
               end else begin
                  state_d = S_DISPLAY;
               end
            end else if (timeout) begin
               state_d     = S_ERROR;
               err_stage_d = cur_q;
            end
         end
         S_DISPLAY: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (bus.current_display == DISP_W'(DISP_LAST)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_ERROR: begin
            if (bus.abort) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = '0;
      if (state_d == S_STAGE && !entry && cnt_q != '1) cnt_d = cnt_q + TO_W'(1);
      else if (state_d == S_STAGE && !entry) cnt_d = cnt_q;

      idle_d   = (state_d == S_IDLE);
      disp_d   = (state_d == S_DISPLAY);
      error_d  = (state_d == S_ERROR);
      active_d = '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
         active_d[i] = (state_d == S_STAGE) && (cur_d == 4'(i));
      end
      start_d = entry ? active_d : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         en_q        <= '0;
         cnt_q       <= '0;
         err_stage_q <= '0;
         idle_q      <= 1'b1;
         disp_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         active_q    <= '0;
         start_q     <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         en_q        <= en_d;
         cnt_q       <= cnt_d;
         err_stage_q <= err_stage_d;
         idle_q      <= idle_d;
         disp_q      <= disp_d;
         done_q      <= done_d;
         error_q     <= error_d;
         active_q    <= active_d;
         start_q     <= start_d;
      end
   end

   assign bus.state_idle    = idle_q;
   assign bus.stage_active  = active_q;
   assign bus.stage_start   = start_q;
   assign bus.state_display = disp_q;
   assign bus.done          = done_q;
   assign bus.error         = error_q;
   assign bus.error_stage   = err_stage_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer; expected stage order is queued at run time.
module tb_stage_sequencer;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int unsigned total  = 0;
   int unsigned passed = 0;
   logic [4:0]  exp_q[$];
   logic [4:0]  oh;

   stage_sequencer_if #(.NUM_STAGES(5), .DISP_W(3), .TO_W(16)) sif ();

   stage_sequencer #(
      .NUM_STAGES(5),
      .DISP_W    (3),
      .DISP_LAST (4),
      .TO_W      (16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (sif)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk("state_onehot", 32'($countones({sif.state_idle, |sif.stage_active,
                                         sif.state_display, sif.error})), 32'd1);
      chk("active_onehot0", 32'($onehot0(sif.stage_active)), 32'd1);
   endtask

   task automatic start_run(input logic [4:0] en, input logic [15:0] lim);
      sif.stage_en      = en;
      sif.timeout_limit = lim;
      for (int i = 0; i < 5; i++) if (en[i]) exp_q.push_back(5'(1 << i));
      sif.run = 1'b1;
      tick();
      sif.run      = 1'b0;
      sif.stage_en = 5'($urandom);
   endtask

   task automatic pop_stage(output logic [4:0] o);
      for (int n = 0; n < 16 && sif.stage_start == '0; n++) tick();
      o = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1f;
      chk("stage_start", 32'(sif.stage_start), 32'(o));
      chk("stage_active", 32'(sif.stage_active), 32'(o));
   endtask

   task automatic finish_stage(input logic [4:0] o);
      tick();
      chk("start_pulse_len", 32'(sif.stage_start), 32'd0);
      repeat (2) tick();
      sif.stage_done = o;
      tick();
      sif.stage_done = '0;
   endtask

   task automatic run_all();
      logic [4:0] s;
      while (exp_q.size() > 0) begin
         pop_stage(s);
         finish_stage(s);
      end
      chk("in_display", 32'(sif.state_display), 32'd1);
   endtask

   task automatic display_exit();
      sif.current_display = 3'd3;
      tick();
      chk("display_hold", 32'(sif.state_display), 32'd1);
      sif.current_display = 3'd4;
      tick();
      chk("exit_idle", 32'(sif.state_idle), 32'd1);
      chk("done_pulse", 32'(sif.done), 32'd1);
      sif.current_display = 3'd0;
      tick();
      chk("done_len", 32'(sif.done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed hang expected finish");
      $fatal(1);
   end

   initial begin
      sif.run = 1'b0; sif.abort = 1'b0; sif.stage_en = '0; sif.stage_done = '0;
      sif.current_display = '0; sif.timeout_limit = '0;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_idle", 32'(sif.state_idle), 32'd1);
      chk("rst_active", 32'(sif.stage_active), 32'd0);
      chk("rst_start", 32'(sif.stage_start), 32'd0);
      chk("rst_display", 32'(sif.state_display), 32'd0);
      chk("rst_done", 32'(sif.done), 32'd0);
      chk("rst_error", 32'(sif.error), 32'd0);
      chk("rst_error_stage", 32'(sif.error_stage), 32'd0);

      // full run
      start_run(5'b11111, 16'd0);
      run_all();
      display_exit();

      // skip mode
      start_run(5'b10101, 16'd0);
      run_all();
      display_exit();
      start_run(5'b00000, 16'd0);
      chk("empty_to_display", 32'(sif.state_display), 32'd1);
      display_exit();

      // abort beats display exit
      start_run(5'b00000, 16'd0);
      sif.current_display = 3'd4;
      sif.abort = 1'b1;
      tick();
      sif.abort = 1'b0;
      sif.current_display = 3'd0;
      chk("abort_disp_idle", 32'(sif.state_idle), 32'd1);
      chk("abort_disp_done", 32'(sif.done), 32'd0);

      // watchdog on stage 2
      start_run(5'b00111, 16'd8);
      pop_stage(oh); finish_stage(oh);
      pop_stage(oh); finish_stage(oh);
      pop_stage(oh);
      for (int c = 2; c <= 8; c++) begin
         tick();
         chk("wd_in_stage", 32'(sif.stage_active), 32'h4);
      end
      tick();
      chk("wd_error", 32'(sif.error), 32'd1);
      chk("wd_error_stage", 32'(sif.error_stage), 32'd2);
      chk("wd_active", 32'(sif.stage_active), 32'd0);
      sif.run = 1'b1; sif.stage_en = 5'b00001;
      tick();
      sif.run = 1'b0;
      chk("err_ignores_run", 32'(sif.error), 32'd1);
      sif.abort = 1'b1;
      tick();
      sif.abort = 1'b0;
      chk("err_abort_idle", 32'(sif.state_idle), 32'd1);
      chk("err_abort_clr", 32'(sif.error), 32'd0);
      chk("err_stage_held", 32'(sif.error_stage), 32'd2);

      // done/timeout collision on stage 1
      start_run(5'b00111, 16'd8);
      pop_stage(oh); finish_stage(oh);
      pop_stage(oh);
      repeat (7) tick();
      sif.stage_done = 5'b00010;
      tick();
      sif.stage_done = '0;
      chk("coll_no_error", 32'(sif.error), 32'd0);
      pop_stage(oh);
      sif.abort = 1'b1; sif.stage_done = 5'b00100;
      tick();
      sif.abort = 1'b0; sif.stage_done = '0;
      chk("abort_done_idle", 32'(sif.state_idle), 32'd1);
      chk("abort_done_nodone", 32'(sif.done), 32'd0);
      tick();
      chk("abort_done_nodone2", 32'(sif.done), 32'd0);

      // stray done, then reset mid-run
      start_run(5'b11111, 16'd0);
      pop_stage(oh); finish_stage(oh);
      pop_stage(oh);
      sif.stage_done = 5'b01000;
      repeat (3) begin
         tick();
         chk("stray_done_hold", 32'(sif.stage_active), 32'h2);
      end
      sif.stage_done = '0;
      finish_stage(oh);
      pop_stage(oh); finish_stage(oh);
      pop_stage(oh);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      chk("mid_rst_idle", 32'(sif.state_idle), 32'd1);
      chk("mid_rst_active", 32'(sif.stage_active), 32'd0);
      chk("mid_rst_done", 32'(sif.done), 32'd0);
      chk("mid_rst_err_stage", 32'(sif.error_stage), 32'd0);
      tick();
      chk("mid_rst_done2", 32'(sif.done), 32'd0);
      sif.run = 1'b1; sif.abort = 1'b1; sif.stage_en = 5'b00001;
      tick();
      sif.run = 1'b0; sif.abort = 1'b0;
      chk("run_abort_idle", 32'(sif.state_idle), 32'd1);
      chk("run_abort_active", 32'(sif.stage_active), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 5, number of pipeline stages (stage 0 = capture, 1 = send, 2 = PE, 3 = SA_3x3, 4 = SA_2x2), range 1..16.
REQ-002 Parameter DISP_W, default 3, width of current_display.
REQ-003 Parameter DISP_LAST, default 4, current_display value that ends the display phase.
REQ-004 Parameter TO_W, default 16, width of the watchdog counter and of timeout_limit.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 run  in  1  start request; sampled only in IDLE.
REQ-009 abort  in  1  return to IDLE from any non-IDLE state.
REQ-010 stage_en  in  NUM_STAGES  per-stage enable mask; a 0 bit skips that stage; latched when run is accepted.
REQ-011 stage_done  in  NUM_STAGES  per-stage completion level; only the bit of the active stage is observed.
REQ-012 current_display  in  DISP_W  display progress index.
REQ-013 timeout_limit  in  TO_W  per-stage cycle budget; 0 disables the watchdog.
REQ-014 state_idle  out  1  high in IDLE.
REQ-015 stage_active  out  NUM_STAGES  one-hot active stage; all zeros outside STAGE.
REQ-016 stage_start  out  NUM_STAGES  one-cycle pulse on the first active cycle of a stage.
REQ-017 state_display  out  1  high in DISPLAY.
REQ-018 done  out  1  one-cycle pulse on the first IDLE cycle after a normal DISPLAY exit.
REQ-019 error  out  1  high in ERROR.
REQ-020 error_stage  out  4  index of the stage that timed out; held until the next ERROR entry or reset.

Function
REQ-021 States SHALL be IDLE, STAGE(k), DISPLAY and ERROR; exactly one of state_idle, |stage_active, state_display or error SHALL be high in every cycle.
REQ-022 All outputs SHALL be registered; a transition decided at edge n is visible after edge n.
REQ-023 In IDLE, when run=1 and abort=0, the block SHALL latch stage_en into en_q and enter STAGE(lowest set bit); if en_q=0 it SHALL enter DISPLAY directly.
REQ-024 In IDLE, when run=1 and abort=1 in the same cycle, the block SHALL remain in IDLE.
REQ-025 In STAGE(k), when stage_done[k]=1 the block SHALL move to STAGE(next set bit of en_q above k); if there is none it SHALL move to DISPLAY; stage_done bits for j!=k SHALL be ignored.
REQ-026 stage_start[k] SHALL pulse for exactly 1 cycle on every entry to STAGE(k), coincident with stage_active[k] rising.
REQ-027 The watchdog counter SHALL clear on stage entry and increment each STAGE cycle, saturating at all-ones.
REQ-028 If timeout_limit!=0, stage_done[k]=0 and count==timeout_limit-1, the block SHALL enter ERROR and capture error_stage=k; a stage is therefore allowed exactly timeout_limit cycles.
REQ-029 If stage_done[k] and the timeout condition coincide, done SHALL win and no ERROR is entered.
REQ-030 timeout_limit SHALL be sampled live; a change mid-stage takes effect immediately.
REQ-031 In DISPLAY, when current_display==DISP_LAST the block SHALL enter IDLE and pulse done.
REQ-032 abort=1 in STAGE, DISPLAY or ERROR SHALL force IDLE on the next edge, with priority over done, timeout and display exit; no done pulse SHALL be produced and error SHALL clear.
REQ-033 ERROR SHALL be left only by abort or reset; run SHALL be ignored in ERROR.
REQ-034 run SHALL be ignored outside IDLE; stage_en changes after acceptance SHALL have no effect until the next run.

Reset
REQ-035 While reset=1 (sampled on clk) the block SHALL enter IDLE; state_idle=1; all other outputs 0; error_stage=0; en_q=0; counter=0; reset SHALL override abort and run.
REQ-036 Reset asserted mid-operation SHALL abandon the sequence with no done pulse.

Verification
REQ-037 Full run: stage_en=5'b11111, timeout_limit=0, run pulse, each stage_done[k] raised 4 cycles after stage_start[k], then current_display=4 -> stage_active walks 00001..10000, 5 stage_start pulses, then DISPLAY, then IDLE with a 1-cycle done pulse.
REQ-038 Skip mode: stage_en=5'b10101 -> only stages 0, 2 and 4 become active; stage_en=0 -> IDLE goes to DISPLAY in 1 cycle.
REQ-039 Watchdog: timeout_limit=8, stage 2 never done -> ERROR on the 8th STAGE(2) cycle, error_stage=2; run ignored; abort -> IDLE with error=0.
REQ-040 Collision: stage_done[1] high in the cycle count==timeout_limit-1 -> advance to stage 2, no ERROR; abort with stage_done -> IDLE.
REQ-041 Stray done: stage_done[3]=1 while in STAGE(1) -> no transition.
REQ-042 Reset mid-operation: reset=1 during STAGE(3) -> next cycle state_idle=1, stage_active=0, done=0; run and abort together in IDLE -> remains IDLE.
